// File: rtl/ecc_secded_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ecc_secded_pipe
// Brief    : Pipelined SEC-DED encoder/checker with valid/ready flow control.
//            Optional saturating error counters when ECC_ERR_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_secded_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_WIDTH   = 16,
    localparam int P = (DATA_WIDTH <= 11) ? 4 :
                       (DATA_WIDTH <= 26) ? 5 :
                       (DATA_WIDTH <= 57) ? 6 : 7,
    localparam int CHECK_WIDTH = P + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_mode,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic [CHECK_WIDTH-1:0] i_check,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [CHECK_WIDTH-1:0] o_check,
    output logic [CHECK_WIDTH-1:0] o_syndrome,
    output logic                   o_sbe,
`ifdef ECC_ERR_COUNT_EN
    input  logic                   i_cnt_clr,
    output logic [CNT_WIDTH-1:0]   o_sbe_count,
    output logic [CNT_WIDTH-1:0]   o_dbe_count,
`endif
    output logic                   o_dbe
);

    // Data bit k lives at the k-th non-power-of-two codeword position (from 3).
    function automatic logic [P-1:0] hamming(input logic [DATA_WIDTH-1:0] data);
        logic [P-1:0] c;
        int           pos;
        c   = '0;
        pos = 2;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            pos = pos + 1;
            if ((pos & (pos - 1)) == 0) pos = pos + 1;
            for (int i = 0; i < P; i++)
                if (pos[i]) c[i] = c[i] ^ data[k];
        end
        return c;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] flip_at(input logic [DATA_WIDTH-1:0] data,
                                                       input logic [P-1:0]          s);
        logic [DATA_WIDTH-1:0] r;
        int                    pos;
        r   = data;
        pos = 2;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            pos = pos + 1;
            if ((pos & (pos - 1)) == 0) pos = pos + 1;
            if (pos == int'(s)) r[k] = ~r[k];
        end
        return r;
    endfunction

    logic [P-1:0]           w_calc;
    logic [CHECK_WIDTH-1:0] w_check_gen;
    logic [CHECK_WIDTH-1:0] w_syn_in;

    always_comb begin
        w_calc      = hamming(i_data);
        w_check_gen = {(^i_data) ^ (^w_calc), w_calc};
        w_syn_in    = '0;
        if (i_mode) w_syn_in = {(^i_data) ^ (^i_check), w_calc ^ i_check[P-1:0]};
    end

    logic                   w_s1_adv;
    logic                   w_s2_adv;
    logic                   w_c_valid;
    logic [DATA_WIDTH-1:0]  w_c_data;
    logic [CHECK_WIDTH-1:0] w_c_check;
    logic [CHECK_WIDTH-1:0] w_c_syn;

    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
            logic                   r_s1_valid_q, w_s1_valid_d;
            logic [DATA_WIDTH-1:0]  r_s1_data_q,  w_s1_data_d;
            logic [CHECK_WIDTH-1:0] r_s1_check_q, w_s1_check_d;
            logic [CHECK_WIDTH-1:0] r_s1_syn_q,   w_s1_syn_d;

            assign w_s1_adv = !r_s1_valid_q || w_s2_adv;

            always_comb begin
                w_s1_valid_d = r_s1_valid_q;
                w_s1_data_d  = r_s1_data_q;
                w_s1_check_d = r_s1_check_q;
                w_s1_syn_d   = r_s1_syn_q;
                if (w_s1_adv) begin
                    w_s1_valid_d = i_valid;
                    if (i_valid) begin
                        w_s1_data_d  = i_data;
                        w_s1_check_d = w_check_gen;
                        w_s1_syn_d   = w_syn_in;
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_s1_valid_q <= 1'b0;
                    r_s1_data_q  <= '0;
                    r_s1_check_q <= '0;
                    r_s1_syn_q   <= '0;
                end else begin
                    r_s1_valid_q <= w_s1_valid_d;
                    r_s1_data_q  <= w_s1_data_d;
                    r_s1_check_q <= w_s1_check_d;
                    r_s1_syn_q   <= w_s1_syn_d;
                end
            end

            assign w_c_valid = r_s1_valid_q;
            assign w_c_data  = r_s1_data_q;
            assign w_c_check = r_s1_check_q;
            assign w_c_syn   = r_s1_syn_q;
        end else begin : g_one_stage
            assign w_s1_adv  = w_s2_adv;
            assign w_c_valid = i_valid;
            assign w_c_data  = i_data;
            assign w_c_check = w_check_gen;
            assign w_c_syn   = w_syn_in;
        end
    endgenerate

    // A parity error with an in-range syndrome is always correctable; flip_at
    // leaves data untouched when the syndrome names a check or parity bit.
    logic [DATA_WIDTH-1:0] w_fix_data;
    logic                  w_fix_sbe;
    logic                  w_fix_dbe;

    always_comb begin
        w_fix_data = w_c_data;
        w_fix_sbe  = 1'b0;
        w_fix_dbe  = 1'b0;
        if (w_c_syn[P]) begin
            if (int'(w_c_syn[P-1:0]) > DATA_WIDTH + P) begin
                w_fix_dbe = 1'b1;
            end else begin
                w_fix_sbe  = 1'b1;
                w_fix_data = flip_at(w_c_data, w_c_syn[P-1:0]);
            end
        end else if (w_c_syn[P-1:0] != '0) begin
            w_fix_dbe = 1'b1;
        end
    end

    logic                   r_s2_valid_q, w_s2_valid_d;
    logic [DATA_WIDTH-1:0]  r_s2_data_q,  w_s2_data_d;
    logic [CHECK_WIDTH-1:0] r_s2_check_q, w_s2_check_d;
    logic [CHECK_WIDTH-1:0] r_s2_syn_q,   w_s2_syn_d;
    logic                   r_s2_sbe_q,   w_s2_sbe_d;
    logic                   r_s2_dbe_q,   w_s2_dbe_d;

    assign w_s2_adv = !r_s2_valid_q || i_ready;

    always_comb begin
        w_s2_valid_d = r_s2_valid_q;
        w_s2_data_d  = r_s2_data_q;
        w_s2_check_d = r_s2_check_q;
        w_s2_syn_d   = r_s2_syn_q;
        w_s2_sbe_d   = r_s2_sbe_q;
        w_s2_dbe_d   = r_s2_dbe_q;
        if (w_s2_adv) begin
            w_s2_valid_d = w_c_valid;
            if (w_c_valid) begin
                w_s2_data_d  = w_fix_data;
                w_s2_check_d = w_c_check;
                w_s2_syn_d   = w_c_syn;
                w_s2_sbe_d   = w_fix_sbe;
                w_s2_dbe_d   = w_fix_dbe;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid_q <= 1'b0;
            r_s2_data_q  <= '0;
            r_s2_check_q <= '0;
            r_s2_syn_q   <= '0;
            r_s2_sbe_q   <= 1'b0;
            r_s2_dbe_q   <= 1'b0;
        end else begin
            r_s2_valid_q <= w_s2_valid_d;
            r_s2_data_q  <= w_s2_data_d;
            r_s2_check_q <= w_s2_check_d;
            r_s2_syn_q   <= w_s2_syn_d;
            r_s2_sbe_q   <= w_s2_sbe_d;
            r_s2_dbe_q   <= w_s2_dbe_d;
        end
    end

    assign o_ready    = w_s1_adv;
    assign o_valid    = r_s2_valid_q;
    assign o_data     = r_s2_data_q;
    assign o_check    = r_s2_check_q;
    assign o_syndrome = r_s2_syn_q;
    assign o_sbe      = r_s2_sbe_q;
    assign o_dbe      = r_s2_dbe_q;

`ifdef ECC_ERR_COUNT_EN
    logic                 w_out_hs;
    logic [CNT_WIDTH-1:0] r_sbe_cnt_q, w_sbe_cnt_d;
    logic [CNT_WIDTH-1:0] r_dbe_cnt_q, w_dbe_cnt_d;

    assign w_out_hs = r_s2_valid_q && i_ready;

    // Clear takes priority over a coincident increment.
    always_comb begin
        w_sbe_cnt_d = r_sbe_cnt_q;
        w_dbe_cnt_d = r_dbe_cnt_q;
        if (i_cnt_clr) begin
            w_sbe_cnt_d = '0;
            w_dbe_cnt_d = '0;
        end else if (w_out_hs) begin
            if (r_s2_sbe_q && (r_sbe_cnt_q != '1)) w_sbe_cnt_d = r_sbe_cnt_q + CNT_WIDTH'(1);
            if (r_s2_dbe_q && (r_dbe_cnt_q != '1)) w_dbe_cnt_d = r_dbe_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sbe_cnt_q <= '0;
            r_dbe_cnt_q <= '0;
        end else begin
            r_sbe_cnt_q <= w_sbe_cnt_d;
            r_dbe_cnt_q <= w_dbe_cnt_d;
        end
    end

    assign o_sbe_count = r_sbe_cnt_q;
    assign o_dbe_count = r_dbe_cnt_q;
`else
    logic w_unused_cnt_width;
    assign w_unused_cnt_width = (CNT_WIDTH > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ecc_secded_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_secded_pipe
// Brief    : Directed + randomized bench for ecc_secded_pipe against a
//            position-list SEC-DED reference model and an in-flight queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_secded_pipe;
    localparam int DW = 32;
    localparam int N  = 38;
`ifdef ECC_ERR_COUNT_EN
    localparam int CNTW = 4;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_mode = 1'b0;
    logic [31:0] i_data = '0;
    logic [6:0]  i_check = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_data;
    logic [6:0]  o_check;
    logic [6:0]  o_syndrome;
    logic        o_sbe;
    logic        o_dbe;
`ifdef ECC_ERR_COUNT_EN
    logic            i_cnt_clr = 1'b0;
    logic [CNTW-1:0] o_sbe_count;
    logic [CNTW-1:0] o_dbe_count;
    int              m_sbe_cnt = 0;
    int              m_dbe_cnt = 0;
`endif

    always #5 i_clk = ~i_clk;

    ecc_secded_pipe #(
        .DATA_WIDTH  (DW),
`ifdef ECC_ERR_COUNT_EN
        .CNT_WIDTH   (CNTW),
`endif
        .PIPE_STAGES (2)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_mode      (i_mode),
        .i_data      (i_data),
        .i_check     (i_check),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_check     (o_check),
        .o_syndrome  (o_syndrome),
        .o_sbe       (o_sbe),
`ifdef ECC_ERR_COUNT_EN
        .i_cnt_clr   (i_cnt_clr),
        .o_sbe_count (o_sbe_count),
        .o_dbe_count (o_dbe_count),
`endif
        .o_dbe       (o_dbe)
    );

    typedef struct {
        logic [31:0] data;
        logic [6:0]  check;
        logic [6:0]  syn;
        logic        sbe;
        logic        dbe;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_stall = -1;
    logic        hold_v = 1'b0;
    logic [48:0] hold_vec = '0;
    logic [47:0] last_out = '0;
    logic        clr_req = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check bits = XOR of the codeword positions of all set data bits.
    function automatic logic [6:0] m_encode(input logic [31:0] d);
        int hp;
        int k;
        hp = 0;
        k  = 0;
        for (int pos = 1; k < DW; pos++) begin
            if ($countones(pos) != 1) begin
                if (d[k]) hp = hp ^ pos;
                k++;
            end
        end
        return {(^d) ^ (^hp[5:0]), hp[5:0]};
    endfunction

    function automatic exp_t m_model(input logic mode, input logic [31:0] d, input logic [6:0] chk);
        exp_t e;
        int   s;
        int   idx;
        logic p;
        e.check = m_encode(d);
        e.data  = d;
        e.syn   = '0;
        e.sbe   = 1'b0;
        e.dbe   = 1'b0;
        e.acc   = 0;
        if (mode) begin
            s     = int'(e.check[5:0] ^ chk[5:0]);
            p     = ^{d, chk};
            e.syn = {p, 6'(s)};
            if (p) begin
                if (s == 0 || $countones(s) == 1) begin
                    e.sbe = 1'b1;
                end else if (s <= N) begin
                    e.sbe = 1'b1;
                    idx = s - $clog2(s) - 1;
                    e.data[idx] = ~e.data[idx];
                end else begin
                    e.dbe = 1'b1;
                end
            end else if (s != 0) begin
                e.dbe = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic step(input logic v, input logic mode, input logic [31:0] d,
                        input logic [6:0] chk, input logic rdy, output logic acc);
        exp_t e;
        logic inc_s;
        logic inc_d;
        inc_s = 1'b0;
        inc_d = 1'b0;
        @(negedge i_clk);
        i_valid = v;
        i_mode  = mode;
        i_data  = d;
        i_check = chk;
        i_ready = rdy;
`ifdef ECC_ERR_COUNT_EN
        i_cnt_clr = clr_req;
`endif
        #1;
        if (hold_v)
            check("hold_outputs", {o_valid, o_data, o_check, o_syndrome, o_sbe, o_dbe}, hold_vec);
        check("o_ready", o_ready, (q.size() < 2) || rdy);
`ifdef ECC_ERR_COUNT_EN
        check("sbe_count", o_sbe_count, m_sbe_cnt);
        check("dbe_count", o_dbe_count, m_dbe_cnt);
`endif
        if (!rdy) last_stall = cyc;
        if (o_valid) check("sbe_dbe_excl", o_sbe & o_dbe, 1'b0);
        if (o_valid && rdy) begin
            if (q.size() == 0) begin
                check("unexpected_valid", o_valid, 1'b0);
            end else begin
                e = q.pop_front();
                check("o_data", o_data, e.data);
                check("o_check", o_check, e.check);
                check("o_syndrome", o_syndrome, e.syn);
                check("o_sbe", o_sbe, e.sbe);
                check("o_dbe", o_dbe, e.dbe);
                if (e.acc > last_stall) check("latency", cyc - e.acc, 2);
                last_out = {o_data, o_check, o_syndrome, o_sbe, o_dbe};
                inc_s = e.sbe;
                inc_d = e.dbe;
            end
        end
        acc = v && o_ready;
        if (acc) begin
            e = m_model(mode, d, chk);
            e.acc = cyc;
            q.push_back(e);
        end
        hold_v   = o_valid && !rdy;
        hold_vec = {o_valid, o_data, o_check, o_syndrome, o_sbe, o_dbe};
`ifdef ECC_ERR_COUNT_EN
        if (clr_req) begin
            m_sbe_cnt = 0;
            m_dbe_cnt = 0;
        end else begin
            if (inc_s && m_sbe_cnt < (1 << CNTW) - 1) m_sbe_cnt++;
            if (inc_d && m_dbe_cnt < (1 << CNTW) - 1) m_dbe_cnt++;
        end
`endif
        cyc++;
    endtask

    task automatic send(input logic mode, input logic [31:0] d, input logic [6:0] chk);
        logic a;
        a = 1'b0;
        for (int t = 0; t < 20 && !a; t++) step(1'b1, mode, d, chk, 1'b1, a);
        if (!a) check("send_timeout", a, 1'b1);
    endtask

    task automatic drain();
        logic a;
        for (int t = 0; t < 10 && q.size() > 0; t++) step(1'b0, 1'b0, '0, '0, 1'b1, a);
        check("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        clr_req = 1'b0;
`ifdef ECC_ERR_COUNT_EN
        i_cnt_clr = 1'b0;
`endif
        @(negedge i_clk);
        i_rst = 1'b0;
        q.delete();
        hold_v = 1'b0;
        cyc += 2;
        last_stall = cyc;
`ifdef ECC_ERR_COUNT_EN
        m_sbe_cnt = 0;
        m_dbe_cnt = 0;
`endif
        #1;
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_outputs", {o_data, o_check, o_syndrome, o_sbe, o_dbe}, 64'd0);
        check("rst_o_ready", o_ready, 1'b1);
`ifdef ECC_ERR_COUNT_EN
        check("rst_counts", {o_sbe_count, o_dbe_count}, 64'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a;
        logic        pend;
        logic        pm;
        logic [31:0] pd;
        logic [6:0]  pc;
        logic [38:0] cw;
        int          nflip;
        int          b0;
        int          b1;

        pend = 1'b0;
        pm = 1'b0;
        pd = '0;
        pc = '0;
        do_reset();

        // Encode all-zero word; latency checked on consumption.
        send(1'b0, 32'h0, 7'h0);
        drain();
        check("enc_zero", last_out, 48'h0);

        // Encode and round-trip a known word.
        send(1'b0, 32'he3a02001, 7'h0);
        drain();
        check("enc_vec_check", last_out[15:9], 7'h70);
        send(1'b1, 32'he3a02001, 7'h70);
        drain();
        check("chk_clean", last_out, {32'he3a02001, 7'h70, 7'h00, 2'b00});

        // Single data-bit error, single check-bit error, double error.
        send(1'b1, 32'he3a02021, 7'h70);
        drain();
        check("sbe_data_fix", {last_out[47:16], last_out[1:0]}, {32'he3a02001, 2'b10});
        send(1'b1, 32'he3a02001, 7'h71);
        drain();
        check("sbe_check_bit", {last_out[47:16], last_out[1:0]}, {32'he3a02001, 2'b10});
        send(1'b1, 32'he3a02002, 7'h70);
        drain();
        check("dbe_flag", {last_out[47:16], last_out[1:0]}, {32'he3a02002, 2'b01});

        // Back-pressure: 4 words with the sink stalled for 3 cycles.
        step(1'b1, 1'b0, 32'h11111111, '0, 1'b0, a);
        step(1'b1, 1'b0, 32'h22222222, '0, 1'b0, a);
        step(1'b1, 1'b0, 32'h33333333, '0, 1'b0, a);
        check("bp_full_not_ready", a, 1'b0);
        step(1'b1, 1'b0, 32'h33333333, '0, 1'b1, a);
        step(1'b1, 1'b0, 32'h44444444, '0, 1'b1, a);
        drain();

        // Randomized traffic with random valid/ready and 0..2 injected flips.
        for (int n = 0; n < 400; n++) begin
            if (!pend) begin
                pm = 1'($urandom_range(0, 1));
                pd = $urandom;
                pc = 7'($urandom);
                if (pm) begin
                    cw    = {m_encode(pd), pd};
                    nflip = $urandom_range(0, 2);
                    b0    = $urandom_range(0, 38);
                    b1    = (b0 + $urandom_range(1, 38)) % 39;
                    if (nflip >= 1) cw[b0] = ~cw[b0];
                    if (nflip == 2) cw[b1] = ~cw[b1];
                    pd = cw[31:0];
                    pc = cw[38:32];
                end
                pend = 1'b1;
            end
            step($urandom_range(0, 3) != 0, pm, pd, pc, $urandom_range(0, 3) != 0, a);
            if (a) pend = 1'b0;
        end
        drain();

        // Reset with words in flight: they must never appear.
        step(1'b1, 1'b0, 32'hdeadbeef, '0, 1'b0, a);
        step(1'b1, 1'b0, 32'hcafef00d, '0, 1'b0, a);
        do_reset();
        for (int n = 0; n < 4; n++) step(1'b0, 1'b0, '0, '0, 1'b1, a);

`ifdef ECC_ERR_COUNT_EN
        for (int n = 0; n < 20; n++) send(1'b1, 32'he3a02021, 7'h70);
        drain();
        check("sbe_count_sat", o_sbe_count, 64'hf);
        send(1'b1, 32'he3a02002, 7'h70);
        step(1'b0, 1'b0, '0, '0, 1'b1, a);
        clr_req = 1'b1;
        step(1'b0, 1'b0, '0, '0, 1'b1, a);
        clr_req = 1'b0;
        step(1'b0, 1'b0, '0, '0, 1'b1, a);
        check("clr_wins", {o_sbe_count, o_dbe_count}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ecc_secded_pipe.md
# ecc_secded_pipe

Parametrised, pipelined SEC-DED (Hamming plus overall parity) engine for the memory error-detection path. It replaces the fixed 32-bit combinational check-bit generator: one instance encodes write data into check bits, or checks read data plus stored check bits, corrects single-bit errors and flags double-bit errors. It sits between the cache/memory datapath and the ECC memory. A valid/ready handshake provides back-pressure, and optional saturating error counters feed status registers.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width; legal 8..120.
- PIPE_STAGES, 2, register stages between input and output; legal 1 or 2.
- CNT_WIDTH, 16, width of each error counter.
- Derived (localparam): P = smallest integer with 2^P >= DATA_WIDTH+P+1; CHECK_WIDTH = P+1. DATA_WIDTH=32 gives 7; DATA_WIDTH=64 gives 8.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input word valid.
- o_ready  out  1  block accepts the input this cycle.
- i_mode  in  1  0 = encode, 1 = check/correct.
- i_data  in  DATA_WIDTH  write data (encode) or read data (check).
- i_check  in  CHECK_WIDTH  stored check bits; used only in check mode.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts the output.
- o_data  out  DATA_WIDTH  input data (encode) or corrected data (check).
- o_check  out  CHECK_WIDTH  generated check bits (encode) or recomputed check bits (check).
- o_syndrome  out  CHECK_WIDTH  {overall parity mismatch, P-bit syndrome}; 0 in encode mode.
- o_sbe  out  1  single-bit error corrected; qualified by o_valid.
- o_dbe  out  1  uncorrectable error; qualified by o_valid.
- i_cnt_clr  in  1  clear both counters (present only with ECC_ERR_COUNT_EN).
- o_sbe_count, o_dbe_count  out  CNT_WIDTH  saturating error counters (present only with ECC_ERR_COUNT_EN).

## Operation
- Codeword positions run 1..DATA_WIDTH+P. Hamming check bit c[i] sits at position 2^i. Data bits fill the non-power-of-two positions in ascending order, so data bit 0 is at position 3.
- c[i] = XOR of all data bits whose position has bit i set. c[P] = XOR of all data bits and c[0..P-1], giving even overall parity.
- Encode: o_check = {c[P], c[P-1:0]}, o_data = i_data, o_sbe = o_dbe = 0.
- Check:
  - s = recomputed c[P-1:0] XOR i_check[P-1:0].
  - p = XOR over all i_data and all i_check bits.
- Classification in check mode:
  - s=0, p=0: clean.
  - p=1, s=0: overall-parity bit error; o_sbe=1, data unchanged.
  - p=1, s is a data position: flip that data bit; o_sbe=1.
  - p=1, s is a check position (power of two): o_sbe=1, data unchanged.
  - p=1, s > DATA_WIDTH+P: o_dbe=1, data passed uncorrected.
  - p=0, s!=0: o_dbe=1, data passed uncorrected.
- o_sbe and o_dbe are never both 1.

## Timing
- Latency is PIPE_STAGES cycles from input acceptance (i_valid & o_ready) to o_valid, with full throughput of one word per cycle.
- With PIPE_STAGES=2, stage 1 registers the syndrome and encode results and stage 2 registers the corrected output.
- Each stage advances when it is empty or its successor advances. Last stage advances on i_ready. o_ready = first stage empty or advancing. o_ready is a combinational function of i_ready.
- While o_valid=1 and i_ready=0, all outputs hold stable.
- Reset values: o_valid=0, all stage valid bits 0, o_data/o_check/o_syndrome = 0, o_sbe = o_dbe = 0, counters = 0. o_ready=1 in the first cycle after reset.
- Reset asserted mid-stream discards all in-flight words. No output handshake completes for them.

## Configuration
- ECC_ERR_COUNT_EN defined:
  - A counter increments by 1 on each output handshake (o_valid & i_ready) carrying o_sbe or o_dbe respectively.
  - Counters saturate at all-ones.
  - i_cnt_clr sets both counters to 0 next cycle. If a clear and an increment fall in the same cycle, the clear wins and the increment is lost.
- ECC_ERR_COUNT_EN undefined: the counter ports and logic are absent.

## Test plan
- Encode 0x00000000 (DATA_WIDTH=32) -> o_check=0x00, o_sbe=o_dbe=0. Output appears 2 cycles after the handshake.
- Encode 0xe3a02001, then check it with the returned check bits -> o_data=0xe3a02001, o_syndrome=0, no error flags.
- Check 0xe3a02021 (bit 5 flipped) with the check bits of 0xe3a02001 -> o_data=0xe3a02001, o_sbe=1. Repeat with i_check bit 0 flipped -> o_sbe=1, data unchanged.
- Check 0xe3a02002 (bits 0 and 1 flipped) -> o_dbe=1, o_data=0xe3a02002.
- Back-pressure: stream 4 words with i_ready held 0 for 3 cycles -> o_ready=0 once both stages are full, no word is lost or duplicated, and output order is preserved.
- ECC_ERR_COUNT_EN with CNT_WIDTH=4:
  - 20 single-bit errors -> o_sbe_count saturates at 15.
  - i_cnt_clr asserted in the same cycle as an error -> both counters read 0.
